// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   state_t      : arbiter FSM encoding (IDLE, HDR, DATA)
//   HDR_ID_MASK  : bits of the header byte that carry the source ID
//   HDR_BASE_DEF : default header base byte (low nibble zero)
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] HDR_ID_MASK  = 4'hF;
  localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bundle of requester-side and UART-side signals of the transmit arbiter.
//   req_data/req_valid/req_last/req_ready : NUM_REQ byte-stream sources
//   tx_data/tx_valid/tx_ready             : shared uart transmit channel
//   grant_id/busy/abort                   : arbiter status
// Modports:
//   master : the arbiter (drives tx_*, req_ready and status)
//   slave  : the environment (sources and uart)
interface uart_tx_arb_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;
  logic                          abort;

  modport master (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, busy, abort
  );

  modport slave (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_id, busy, abort
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker.
//   req        : request vector
//   last_grant : index granted most recently; search starts one above it
//   found      : at least one request is set
//   index      : first set request found searching upward with wrap
module uart_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          found,
  output logic [IW-1:0] index
);

  always_comb begin
    int unsigned cand;
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (int'(last_grant) + off) % N;
      if (!found && req[cand]) begin
        found = 1'b1;
        index = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin frame arbiter in front of a single uart transmit channel.
// Each granted frame is sent atomically, prefixed by a header byte
// HDR_BASE | id; a frame whose owner stalls for TIMEOUT_CYC cycles is aborted.
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : requester streams, uart channel and status (master view)
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned            NUM_REQ     = 4,
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0]  HDR_BASE    = DATA_WIDTH'(HDR_BASE_DEF),
  parameter int unsigned            TIMEOUT_CYC = 1024
) (
  input logic           clk,
  input logic           rstn,
  uart_tx_arb_if.master bus
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // Abort fires in the starved cycle in which the count would reach TIMEOUT_CYC.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_t                state, state_nxt;
  logic [ID_W-1:0]       grant_q;
  logic [ID_W-1:0]       last_grant_q;
  logic [WD_W-1:0]       wd_cnt;
  logic                  found;
  logic [ID_W-1:0]       pick;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic [DATA_WIDTH-1:0] hdr_byte;
  logic                  data_hs;
  logic                  starve;
  logic                  wd_hit;

  uart_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .found      (found),
    .index      (pick)
  );

  assign own_valid = bus.req_valid[grant_q];
  assign own_last  = bus.req_last[grant_q];
  assign own_data  = bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign hdr_byte  = HDR_BASE | (DATA_WIDTH'(grant_q) & DATA_WIDTH'(HDR_ID_MASK));

  assign data_hs = (state == DATA) && own_valid && bus.tx_ready;
  // Only an owner with nothing to offer counts as stalled; uart backpressure does not.
  assign starve  = (state == DATA) && !own_valid;
  assign wd_hit  = (TIMEOUT_CYC != 0) && starve && (wd_cnt == WD_LAST);

  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = grant_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.req_ready = '0;
    bus.abort     = 1'b0;
    case (state)
      IDLE: begin
        if (found) state_nxt = HDR;
      end
      HDR: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = hdr_byte;
        if (bus.tx_ready) state_nxt = DATA;
      end
      DATA: begin
        bus.tx_valid           = own_valid;
        bus.tx_data            = own_data;
        bus.req_ready[grant_q] = bus.tx_ready;
        if (data_hs && own_last) begin
          state_nxt = IDLE;
        end else if (wd_hit) begin
          bus.abort = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      wd_cnt       <= '0;
    end else begin
      if (state == IDLE && found) grant_q <= pick;
      if (state == DATA && state_nxt == IDLE) last_grant_q <= grant_q;
      // Held at zero outside DATA, so it is already clear on entry.
      if (state_nxt != DATA || data_hs) wd_cnt <= '0;
      else if (starve && TIMEOUT_CYC != 0) wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arb #(
    .NUM_REQ     (NR),
    .DATA_WIDTH  (DW),
    .HDR_BASE    (8'hA0),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [8:0]  mem[NR][64];
  int unsigned rd[NR] = '{default: 0};
  int unsigned wr[NR] = '{default: 0};
  int          cyc = 0;
  int          last_hs_cyc = 0;
  int          abort_cnt = 0;
  int          abort_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every uart handshake consumes one expected byte.
  always @(negedge clk) begin
    if (rstn && bus.tx_valid && bus.tx_ready) begin
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_extra got=%0h required=none", bus.tx_data);
      end else begin
        check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
    end
    if (rstn && bus.abort) begin
      abort_cnt++;
      abort_gap = cyc - last_hs_cyc;
    end
  end

  // Requester model: each source presents the head of its byte queue.
  initial begin : feeder
    logic [NR-1:0]    fired;
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    logic [8:0]       ent;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      fired = bus.req_ready & bus.req_valid;
      @(posedge clk);
      #1;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
        if (fired[i] && rstn) rd[i]++;
        if (rd[i] != wr[i]) begin
          ent          = mem[i][rd[i] % 64];
          v[i]         = 1'b1;
          l[i]         = ent[8];
          d[i*DW +: DW] = ent[7:0];
        end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic last);
    mem[i][wr[i] % 64] = {last, b};
    wr[i]++;
  endtask

  function automatic bit reqs_empty();
    for (int i = 0; i < NR; i++) if (rd[i] != wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !reqs_empty()) && n < budget) begin
      nedge();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || !reqs_empty()) begin
      errors++;
      $display("FAIL %s_drain left=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic wait_busy(input string name, input logic [1:0] id);
    int n = 0;
    while (!(bus.busy && bus.grant_id == id) && n < 50) begin
      nedge();
      n++;
    end
    check({name, "_grant"}, {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    #3;
    check("rst_tx_valid",  {31'd0, bus.tx_valid}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy},     32'd0);
    check("rst_abort",     {31'd0, bus.abort},    32'd0);
    check("rst_req_ready", 32'(bus.req_ready),    32'd0);
    check("rst_tx_data",   32'(bus.tx_data),      32'd0);
    check("rst_grant_id",  32'(bus.grant_id),     32'd0);
    for (int i = 0; i < NR; i++) wr[i] = rd[i];
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout got=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    int bubbles;
    int n;
    bit started;
    int bad;
    int abase;
    bus.tx_ready = 1'b0;
    #1;
    apply_reset();

    // Two-byte frame from req 1, cycle by cycle.
    bus.tx_ready = 1'b1;
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    nedge();
    nedge();
    check("t1_wait_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("t1_wait_busy",     {31'd0, bus.busy},     32'd0);
    nedge();
    check("t1_hdr_tx_valid",  {31'd0, bus.tx_valid}, 32'd1);
    check("t1_hdr_grant",     32'(bus.grant_id),     32'd1);
    check("t1_hdr_req_ready", 32'(bus.req_ready),    32'd0);
    nedge();
    check("t1_d0_req_ready",  32'(bus.req_ready),    32'h2);
    nedge();
    check("t1_d1_req_ready",  32'(bus.req_ready),    32'h2);
    nedge();
    check("t1_after_busy",    {31'd0, bus.busy},     32'd0);
    check("t1_after_ready",   32'(bus.req_ready),    32'd0);
    drain("t1", 50);

    // All four sources with one-byte frames straight after reset.
    apply_reset();
    bus.tx_ready = 1'b1;
    push(0, 8'h50, 1'b1); push(1, 8'h51, 1'b1); push(2, 8'h52, 1'b1);
    push(3, 8'h53, 1'b1); push(0, 8'h54, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h50);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h51);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h52);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h53);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h54);
    bubbles = 0; started = 0; n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      nedge();
      n++;
      if (bus.busy) started = 1;
      else if (started) bubbles++;
    end
    check("t2_bubbles", 32'(bubbles), 32'd4);
    drain("t2", 20);

    // Req 0 asks while req 2 is mid-frame; it waits, and 3 is skipped.
    push(2, 8'h60, 1'b0); push(2, 8'h61, 1'b0); push(2, 8'h62, 1'b0);
    push(2, 8'h63, 1'b0); push(2, 8'h64, 1'b1);
    exp_q.push_back(8'hA2);
    for (int b = 0; b < 5; b++) exp_q.push_back(8'(8'h60 + b));
    wait_busy("t3", 2'd2);
    tick();
    push(0, 8'h70, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h70);
    drain("t3", 50);

    // Long uart backpressure with valid held: no abort, data stable.
    bus.tx_ready = 1'b0;
    abase = abort_cnt;
    push(1, 8'h81, 1'b0); push(1, 8'h82, 1'b1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h81); exp_q.push_back(8'h82);
    wait_busy("t4", 2'd1);
    tick(); bus.tx_ready = 1'b1;
    tick(); bus.tx_ready = 1'b0;
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      nedge();
      if (!bus.tx_valid || bus.tx_data != 8'h81 || !bus.busy) bad++;
    end
    check("t4_stall_stable", 32'(bad), 32'd0);
    check("t4_no_abort", 32'(abort_cnt - abase), 32'd0);
    bus.tx_ready = 1'b1;
    drain("t4", 50);

    // Req 3 sends one non-last byte then goes quiet.
    abase = abort_cnt;
    push(3, 8'h93, 1'b0);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h93);
    n = 0;
    while (abort_cnt == abase && n < 100) begin
      nedge();
      n++;
    end
    check("t5_abort_seen", 32'(abort_cnt - abase), 32'd1);
    check("t5_abort_gap", 32'(abort_gap), 32'd16);
    nedge();
    check("t5_idle_after", {31'd0, bus.busy},  32'd0);
    check("t5_abort_pulse", {31'd0, bus.abort}, 32'd0);
    push(0, 8'hB0, 1'b1); push(1, 8'hB1, 1'b1); push(2, 8'hB2, 1'b1); push(3, 8'hB3, 1'b1);
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(8'(8'hA0 + r));
      exp_q.push_back(8'(8'hB0 + r));
    end
    drain("t5", 100);
    check("t5_abort_total", 32'(abort_cnt - abase), 32'd1);

    // Reset during req 1's data phase; afterwards req 0 wins again.
    push(0, 8'hD0, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hD0);
    drain("t6_pre", 50);
    bus.tx_ready = 1'b0;
    push(1, 8'hC1, 1'b0); push(1, 8'hC2, 1'b1);
    exp_q.push_back(8'hA1);
    wait_busy("t6", 2'd1);
    tick(); bus.tx_ready = 1'b1;
    tick(); bus.tx_ready = 1'b0;
    nedge();
    check("t6_in_data_valid", {31'd0, bus.tx_valid}, 32'd1);
    check("t6_in_data_byte", 32'(bus.tx_data), 32'hC1);
    check("t6_hdr_consumed", 32'(exp_q.size()), 32'd0);
    tick();
    apply_reset();
    bus.tx_ready = 1'b1;
    push(1, 8'hE1, 1'b1); push(0, 8'hE0, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hE0);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hE1);
    drain("t6", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin frame arbiter that shares the single transmit channel of `uart` (its `data_from_sensor` / `valid_from_sensor` / `ready_to_sensor` handshake) between `NUM_REQ` independent byte-stream sources. Each frame is granted atomically. The arbiter prefixes the frame with a header byte that carries the source ID, and aborts a frame whose owner stalls too long. It sits between the sensor/status producers and the `uart` instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_WIDTH`, 8, byte width; must match `uart`
- `HDR_BASE`, 8'hA0, header byte = `HDR_BASE | id` (low 4 bits of `HDR_BASE` must be 0)
- `TIMEOUT_CYC`, 1024, consecutive starved cycles before abort; 0 disables the watchdog
- `clk`  in  1  single clock
- `rstn`  in  1  asynchronous, active-low reset
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i byte at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_valid`  in  NUM_REQ  byte valid per requester
- `req_last`  in  NUM_REQ  marks final byte of frame
- `req_ready`  out  NUM_REQ  byte accepted from requester i
- `tx_data`  out  DATA_WIDTH  to `uart.data_from_sensor`
- `tx_valid`  out  1  to `uart.valid_from_sensor`
- `tx_ready`  in  1  from `uart.ready_to_sensor`
- `grant_id`  out  $clog2(NUM_REQ)  current owner; valid while `busy`
- `busy`  out  1  state != IDLE
- `abort`  out  1  one-cycle pulse on watchdog abort

## Operation
- FSM states: IDLE, HDR, DATA.
- **IDLE**
  - `tx_valid`=0, `req_ready`=0.
  - If any `req_valid`: pick the first set bit searching from `last_grant+1` upward with wrap, register it in `grant_id`, go to HDR.
- **HDR**
  - `tx_valid`=1, `tx_data`=`HDR_BASE | grant_id`.
  - On `tx_valid & tx_ready`, go to DATA.
- **DATA** (combinational pass-through of owner g)
  - `tx_valid`=`req_valid[g]`, `tx_data`=byte g, `req_ready[g]`=`tx_ready`; all other `req_ready` are 0.
  - On handshake with `req_last[g]`: `last_grant`←g, go to IDLE.
- **Watchdog**
  - The counter clears on entry to DATA and on every handshake.
  - It increments on each DATA cycle with `req_valid[g]`=0. Cycles with `tx_ready`=0 and `req_valid[g]`=1 do not count.
  - When the counter reaches `TIMEOUT_CYC`: pulse `abort`, `last_grant`←g, go to IDLE.
  - The truncated frame is not padded.
- Requests that arrive after a grant wait for the frame to end. There is no preemption.
- A requester that deasserts `req_valid` in IDLE loses its pending arbitration. This is legal.
- A single-byte frame (`req_last` on the first byte) is legal: header, then one byte.

## Timing
- Reset values:
  - state=IDLE, `last_grant`=NUM_REQ-1 (so req 0 wins first), watchdog counter=0.
  - `grant_id`=0, `busy`=0, `abort`=0, `tx_valid`=0, `req_ready`=0, `tx_data`=0.
- Request to header: `req_valid` sampled high in IDLE at edge k puts `tx_valid` high with the header in cycle k+1.
- Data latency: zero. `req_ready` and `tx_valid` in DATA are combinational from inputs and the registered state.
- Back-to-back frames: after the last-byte handshake, exactly 1 IDLE bubble cycle, then the next HDR.
- Sustained transfer:
  - An N-byte frame occupies N+1 UART handshakes.
  - `busy` is high from the HDR cycle through the last-byte handshake cycle.
- Simultaneous events:
  - Last-byte handshake and a watchdog hit cannot coincide, because a handshake clears the counter.
  - In the same cycle as a last-byte handshake, a requester's new `req_valid` is ignored until IDLE.
- Reset mid-frame returns to IDLE immediately.
  - The `uart` instance shares `rstn`, so a partial character on the line is acceptable.

## Structure
- Package `uart_arb_pkg`: the `state_t` enum (IDLE, HDR, DATA), `HDR_ID_MASK`=4'hF, and the default `HDR_BASE` constant.
- Sub-module `uart_rr_pick`:
  - Purely combinational rotating priority picker.
  - Inputs: request vector, `last_grant`. Outputs: `found`, `index`.
- The top holds the FSM, the `grant_id` / `last_grant` registers, the watchdog counter and the mux/demux.

## Test plan
- Single frame, req 1 sends 8'h11, 8'h22 (last), `tx_ready` always 1 -> `tx_data` sequence 8'hA1, 8'h11, 8'h22; `req_ready[1]` high exactly 2 cycles; `busy` low 1 cycle after.
- All 4 requesters valid continuously with 1-byte frames after reset -> headers A0, A1, A2, A3, A0 in order; one IDLE bubble between frames.
- Req 2 mid-frame while req 0 asserts valid -> req 0 not granted until req 2's last handshake; next header A0 (wrap from 2 to 3 skipped since 3 idle).
- Backpressure: `tx_ready` low 2000 cycles with `req_valid` held high, `TIMEOUT_CYC`=1024 -> no abort; data unchanged, then completes.
- Starvation: req 3 sends one non-last byte then drops valid, `TIMEOUT_CYC`=16 -> `abort` pulses exactly 16 DATA cycles after the handshake; IDLE next cycle; next grant goes to req 0 when all request.
- `rstn` asserted during DATA of req 1 -> `tx_valid`, `busy`, `req_ready` go 0 asynchronously; after release, the first grant goes to req 0.
